// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC generation, a bounded number of
// in-flight imem requests, and a prefetch queue drained by decode.
module fetch_queue_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0100_0000,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          d_pc,
  output logic [31:0]              d_insn,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = OW + CW;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [31:0]     q_insn [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [OW-1:0]   count;
  logic [CW-1:0]   outstanding, discard, live;
  logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_wr, tag_rd, tag_wr_nxt, tag_rd_nxt;
  logic [SW-1:0]   fill;
  logic            accept, rsp_fire, push, pop;
  logic [1:0]      unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Queue space is reserved for every live in-flight request, so a push can never overflow.
  always_comb begin
    live           = outstanding - discard;
    fill           = SW'(count) + SW'(live);
    imem_req_valid = !reset && !redirect_valid
                     && (outstanding < CW'(MAX_OUTSTANDING))
                     && (fill < SW'(DEPTH));
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && (outstanding != '0);
    push           = rsp_fire && (discard == '0) && !redirect_valid;
    d_valid        = (count != '0);
    pop            = d_valid && d_ready && !redirect_valid;
    d_pc           = d_valid ? q_pc[head]   : '0;
    d_insn         = d_valid ? q_insn[head] : '0;
    occupancy      = count;
    tag_wr_nxt     = (tag_wr == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + TW'(1);
    tag_rd_nxt     = (tag_rd == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept)
        fetch_pc <= fetch_pc + XLEN'(4);

      outstanding <= outstanding + CW'(accept) - CW'(rsp_fire);
      if (accept)   tag_wr <= tag_wr_nxt;
      if (rsp_fire) tag_rd <= tag_rd_nxt;

      // Everything still in flight after this cycle's response becomes stale.
      if (redirect_valid)
        discard <= outstanding - CW'(rsp_fire);
      else if (rsp_fire && (discard != '0))
        discard <= discard - CW'(1);

      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count <= count + OW'(push) - OW'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept)
      tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      q_pc[tail]   <= tag_mem[tag_rd];
      q_insn[tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table plus randomized traffic
// against a queue-based reference model and an in-order variable-latency memory.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] B      = 32'h0100_0000;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_insn;
  logic [2:0]  occupancy;

  fetch_queue_unit #(
    .XLEN(32),
    .RESET_PC(RST_PC),
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .d_valid(d_valid),
    .d_ready(d_ready),
    .d_pc(d_pc),
    .d_insn(d_insn),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int unsigned due; logic [31:0] data; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct {
    bit          kind;   // 1: run the reset sequence instead of a cycle
    logic [3:0]  ctl;    // {rst, rdy, drdy, redirect}
    logic [31:0] rpc;
    int unsigned lat;
    logic [1:0]  ev;     // {req_valid, d_valid}
    logic [31:0] ea;
    logic [31:0] edpc;
    logic [2:0]  eocc;
  } row_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  mem_t        mem_q[$];
  ent_t        m_q[$];
  out_t        m_out[$];
  logic [31:0] m_pc;
  bit          m_rv;
  bit          model_ok = 0;
  row_t        tbl[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic row_t r(input logic [3:0] ctl, input logic [31:0] rpc,
                             input int unsigned lat, input logic [1:0] ev,
                             input logic [31:0] ea, input logic [31:0] edpc,
                             input logic [2:0] eocc);
    row_t x;
    x.kind = 1'b0; x.ctl = ctl; x.rpc = rpc; x.lat = lat;
    x.ev = ev; x.ea = ea; x.edpc = edpc; x.eocc = eocc;
    return x;
  endfunction

  function automatic row_t rs();
    row_t x;
    x = r(4'b0000, 32'h0, 1, 2'b00, 32'h0, 32'h0, 3'd0);
    x.kind = 1'b1;
    return x;
  endfunction

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic model_check();
    int unsigned live;
    live = 0;
    foreach (m_out[i]) if (!m_out[i].stale) live++;
    m_rv = !reset && !redirect_valid && (m_out.size() < MAXO)
           && ((m_q.size() + live) < DEPTH);
    if (model_ok) begin
      check1("m_req_valid", imem_req_valid, m_rv);
      if (m_rv) check32("m_req_addr", imem_req_addr, m_pc);
      check1("m_d_valid", d_valid, m_q.size() != 0);
      check32("m_occupancy", 32'(occupancy), 32'(m_q.size()));
      if (m_q.size() != 0) begin
        check32("m_d_pc", d_pc, m_q[0].pc);
        check32("m_d_insn", d_insn, m_q[0].insn);
      end
    end
  endtask

  task automatic model_update();
    ent_t e, drop;
    out_t o;
    bit   have;
    if (reset) begin
      m_pc = RST_PC;
      m_q.delete();
      m_out.delete();
    end else begin
      have = 0;
      if (imem_rsp_valid && m_out.size() != 0) begin
        o = m_out.pop_front();
        if (!o.stale) begin
          have = 1;
          e.pc = o.pc;
          e.insn = imem_rsp_data;
        end
      end
      if (redirect_valid) begin
        m_q.delete();
        foreach (m_out[i]) m_out[i].stale = 1'b1;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_q.size() != 0 && d_ready) drop = m_q.pop_front();
        if (have) m_q.push_back(e);
        if (m_rv && imem_req_ready) begin
          o.pc = m_pc;
          o.stale = 1'b0;
          m_out.push_back(o);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] rpc);
    @(negedge clock);
    {reset, imem_req_ready, d_ready, redirect_valid} = ctl;
    redirect_pc = rpc;
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
    model_check();
  endtask

  task automatic tick(input int unsigned lat);
    logic        acc;
    logic [31:0] a;
    int unsigned due;
    mem_t        m;
    acc = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clock);
    if (imem_rsp_valid) m = mem_q.pop_front();
    if (acc) begin
      due = cyc + lat;
      if (mem_q.size() != 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
      m.due = due;
      m.data = mem_word(a);
      mem_q.push_back(m);
    end
    model_update();
    cyc++;
  endtask

  task automatic reset_seq();
    mem_q.delete();
    drive(4'b1110, 32'h0);
    check1("rst_req_valid_first", imem_req_valid, 1'b0);
    tick(1);
    model_ok = 1;
    drive(4'b1110, 32'h0);
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_d_valid", d_valid, 1'b0);
    check32("rst_occupancy", 32'(occupancy), 32'd0);
    check32("rst_d_pc", d_pc, 32'h0);
    check32("rst_d_insn", d_insn, 32'h0);
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  ctl;
    logic [31:0] rpc;
    row_t        x;

    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b0;

    // Sequential fetch, 1-cycle memory, decode always ready
    tbl.push_back(rs());
    tbl.push_back(r(4'b0110, 0, 1, 2'b10, B,          0,          3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b10, B + 32'h4,  0,          3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h8,  B,          3'd1));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'hC,  B + 32'h4,  3'd1));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h10, B + 32'h8,  3'd1));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h14, B + 32'hC,  3'd1));
    // Decode stalled: queue fills to DEPTH, then drains one per cycle
    tbl.push_back(rs());
    tbl.push_back(r(4'b0100, 0, 1, 2'b10, B,          0,          3'd0));
    tbl.push_back(r(4'b0100, 0, 1, 2'b10, B + 32'h4,  0,          3'd0));
    tbl.push_back(r(4'b0100, 0, 1, 2'b11, B + 32'h8,  B,          3'd1));
    tbl.push_back(r(4'b0100, 0, 1, 2'b11, B + 32'hC,  B,          3'd2));
    tbl.push_back(r(4'b0100, 0, 1, 2'b01, 0,          B,          3'd3));
    tbl.push_back(r(4'b0100, 0, 1, 2'b01, 0,          B,          3'd4));
    tbl.push_back(r(4'b0100, 0, 1, 2'b01, 0,          B,          3'd4));
    tbl.push_back(r(4'b0110, 0, 1, 2'b01, 0,          B,          3'd4));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h10, B + 32'h4,  3'd3));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h14, B + 32'h8,  3'd2));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h18, B + 32'hC,  3'd2));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h1C, B + 32'h10, 3'd2));
    // Memory not ready: address held
    tbl.push_back(rs());
    for (int i = 0; i < 5; i++)
      tbl.push_back(r(4'b0010, 0, 1, 2'b10, B, 0, 3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b10, B,          0,          3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b10, B + 32'h4,  0,          3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h8,  B,          3'd1));
    // Redirect with two stale in-flight responses, 3-cycle memory
    tbl.push_back(rs());
    tbl.push_back(r(4'b0110, 0,            3, 2'b10, B,           0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b10, B + 32'h4,   0,           3'd0));
    tbl.push_back(r(4'b0111, B + 32'h102,  3, 2'b00, 0,           0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b00, 0,           0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b10, B + 32'h100, 0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b10, B + 32'h104, 0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b00, 0,           0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b00, 0,           0,           3'd0));
    tbl.push_back(r(4'b0110, 0,            3, 2'b11, B + 32'h108, B + 32'h100, 3'd1));
    // Redirect coinciding with a push and a pop
    tbl.push_back(rs());
    tbl.push_back(r(4'b0100, 0,             1, 2'b10, B,             0,             3'd0));
    tbl.push_back(r(4'b0100, 0,             1, 2'b10, B + 32'h4,     0,             3'd0));
    tbl.push_back(r(4'b0100, 0,             1, 2'b11, B + 32'h8,     B,             3'd1));
    tbl.push_back(r(4'b0111, 32'h0200_0000, 1, 2'b01, 0,             B,             3'd2));
    tbl.push_back(r(4'b0110, 0,             1, 2'b10, 32'h0200_0000, 0,             3'd0));
    tbl.push_back(r(4'b0110, 0,             1, 2'b10, 32'h0200_0004, 0,             3'd0));
    tbl.push_back(r(4'b0110, 0,             1, 2'b11, 32'h0200_0008, 32'h0200_0000, 3'd1));
    // Reset mid-operation with a late response afterwards
    tbl.push_back(rs());
    tbl.push_back(r(4'b0100, 0, 2, 2'b10, B,          0, 3'd0));
    tbl.push_back(r(4'b0100, 0, 2, 2'b10, B + 32'h4,  0, 3'd0));
    tbl.push_back(r(4'b0100, 0, 2, 2'b00, 0,          0, 3'd0));
    tbl.push_back(r(4'b0100, 0, 2, 2'b11, B + 32'h8,  B, 3'd1));
    tbl.push_back(r(4'b0100, 0, 3, 2'b11, B + 32'hC,  B, 3'd2));
    tbl.push_back(r(4'b0100, 0, 1, 2'b01, 0,          B, 3'd2));
    tbl.push_back(r(4'b1100, 0, 1, 2'b01, 0,          B, 3'd3));
    tbl.push_back(r(4'b0110, 0, 1, 2'b10, B,          0, 3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b10, B + 32'h4,  0, 3'd0));
    tbl.push_back(r(4'b0110, 0, 1, 2'b11, B + 32'h8,  B, 3'd1));

    foreach (tbl[i]) begin
      x = tbl[i];
      if (x.kind) begin
        reset_seq();
      end else begin
        drive(x.ctl, x.rpc);
        check1($sformatf("t%0d_req_valid", i), imem_req_valid, x.ev[1]);
        if (x.ev[1]) check32($sformatf("t%0d_req_addr", i), imem_req_addr, x.ea);
        check1($sformatf("t%0d_d_valid", i), d_valid, x.ev[0]);
        check32($sformatf("t%0d_occupancy", i), 32'(occupancy), 32'(x.eocc));
        if (x.ev[0]) begin
          check32($sformatf("t%0d_d_pc", i), d_pc, x.edpc);
          check32($sformatf("t%0d_d_insn", i), d_insn, mem_word(x.edpc));
        end
        tick(x.lat);
      end
    end

    // Randomized traffic, including redirects near the top of the address space
    reset_seq();
    for (int i = 0; i < 3000; i++) begin
      ctl[3] = ($urandom_range(0, 199) == 0);
      ctl[2] = ($urandom_range(0, 9) < 7);
      ctl[1] = ($urandom_range(0, 9) < 6);
      ctl[0] = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else
        rpc = 32'h0100_0000 + ($urandom() & 32'h3FF);
      drive(ctl, rpc);
      tick($urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the 5-stage core. Replaces the single-register IF stage.
- Generates sequential PCs and issues requests to a variable-latency instruction memory over a valid/ready interface.
- Buffers returned instructions in a DEPTH-entry prefetch queue that decode drains with valid/ready.
- On an EX-stage redirect (taken branch or jump), it flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h01000000, PC loaded on reset
DEPTH, 4, prefetch queue entries; power of 2, at least 2
MAX_OUTSTANDING, 2, maximum unanswered imem requests; at least 1

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  word-aligned fetch address
imem_rsp_valid  input  1  response valid; responses return in request order, always accepted
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  EX redirect (br_taken or jal)
redirect_pc  input  XLEN  redirect target; bits [1:0] forced to 0
d_valid  output  1  queue head valid to decode
d_ready  input  1  decode consumes head (low when decode stalls)
d_pc  output  XLEN  PC of head entry
d_insn  output  32  instruction of head entry
occupancy  output  $clog2(DEPTH)+1  queued entries

Behaviour:
- Reset state: fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0.
- Reset outputs: imem_req_valid=0 during the reset cycle, d_valid=0, occupancy=0, d_pc=0, d_insn=0.
- Reset mid-operation clears everything. A response arriving while outstanding==0 is dropped.
- Counters:
  - outstanding: requests accepted but not yet responded.
  - discard: how many of the outstanding responses are stale; always ≤ outstanding.
  - live = outstanding − discard.
- Issue condition (combinational):
  - imem_req_valid = !reset && !redirect_valid && outstanding<MAX_OUTSTANDING && (occupancy+live)<DEPTH.
  - Queue space is reserved at issue, so a push never finds the queue full.
  - imem_req_valid must not depend on imem_req_ready.
- imem_req_addr = fetch_pc. Address is held stable while valid && !ready.
- On accept (valid&&ready):
  - fetch_pc += 4 (wraps modulo 2^XLEN).
  - outstanding++.
  - Request PC pushed into an internal MAX_OUTSTANDING-deep pc-tag FIFO.
- On response:
  - outstanding−− and the tag is popped.
  - If discard>0: discard−−, data dropped.
  - Otherwise: {tag, imem_rsp_data} pushed to the queue tail, visible on d_* the next cycle. There is no bypass.
- Minimum latency: request accepted in cycle N, response at N+1, d_valid at N+2.
- Head outputs: d_valid = occupancy!=0; d_pc/d_insn = head entry. Entry pops on d_valid&&d_ready.
- Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo DEPTH.
- Redirect (highest priority, takes effect at the clock edge):
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue cleared; any same-cycle push or pop is ignored.
  - discard <= outstanding after this cycle's response. No request is issued in the redirect cycle, so none is counted.
  - d_valid=0 in the following cycle.
  - The first request to the new PC can issue the cycle after the redirect.
- Back-to-back redirects: the later one wins; discard is recomputed each time.
- When occupancy==DEPTH, imem_req_valid=0 until a pop frees space.

Test Plan:
- Reset, MAX_OUTSTANDING=2, imem ready, 1-cycle latency, d_ready=1 → requests to 0x01000000, 0x01000004, 0x01000008, …; d_valid first high 2 cycles after the first accept; d_pc follows the same sequence with matching d_insn.
- Hold d_ready=0, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0 with occupancy=4. Raise d_ready → one pop per cycle and fetch resumes at 0x01000010.
- imem_req_ready=0 for 5 cycles → imem_req_addr held at 0x01000000, imem_req_valid stays 1, fetch_pc unchanged, no d_valid.
- 3-cycle latency, 2 outstanding, redirect_valid with redirect_pc=0x01000102 → both stale responses dropped; next request address 0x01000100; first d_pc after the redirect = 0x01000100.
- Redirect in the same cycle as a push and a pop with occupancy=2 → occupancy=0 and d_valid=0 next cycle; the pushed instruction never appears on d_*.
- Assert reset with occupancy=3 and 1 outstanding → next cycle occupancy=0 and d_valid=0; a late imem_rsp_valid is ignored; first request after reset uses 0x01000000.
